cap_play_sequencer: RTL

Sequences multi-board capture/playback triggering for the SYSREF-aligned trigger-sync block. The sequencer runs in the pl_adc_clk domain and accepts a software start command. It waits a programmed number of SYSREF rising edges, then drives capture_in and/or play_in high for a programmed window, followed by a holdoff gap. It also reports status: busy, done, SYSREF-timeout error and rejected-command.

---
 rtl/cap_play_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/cap_play_sequencer.sv
// -----------------------------------------------------------------------------
// cap_play_sequencer
//
// Sequences capture/playback triggering for the SYSREF-aligned trigger-sync
// block. A software start arms the sequencer. It then waits for
// (cfg_dly_edges + 1) synchronized SYSREF rising edges and drives capture_in
// and/or play_in for a window of cfg_len cycles (0 is treated as 1). A
// holdoff gap of cfg_gap cycles follows before the sequencer returns to IDLE.
//
// Ports:
//   pl_adc_clk, pl_rst        clock, synchronous active-high reset
//   pl_sysref                 raw SYSREF, asynchronous to pl_adc_clk
//   master                    1 = this board originates triggers; a fall
//                             while busy aborts the run
//   cmd_start, cmd_abort      single-cycle commands
//   cmd_capture_en/play_en    outputs to drive in this run
//   cfg_dly_edges/len/gap     run configuration, latched on an accepted start
//   capture_in, play_in       registered trigger requests
//   busy, done, rejected      status; done and rejected are one-cycle pulses
//   timeout_err               sticky; SYSREF went missing while armed
//   sysref_cnt                free-running count of detected SYSREF edges
// -----------------------------------------------------------------------------
module cap_play_sequencer #(
   parameter int LEN_W          = 16,
   parameter int DLY_W          = 4,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int SYNC_STAGES    = 2
) (
   input  logic             pl_adc_clk,
   input  logic             pl_rst,
   input  logic             pl_sysref,
   input  logic             master,
   input  logic             cmd_start,
   input  logic             cmd_abort,
   input  logic             cmd_capture_en,
   input  logic             cmd_play_en,
   input  logic [DLY_W-1:0] cfg_dly_edges,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic [LEN_W-1:0] cfg_gap,
   output logic             capture_in,
   output logic             play_in,
   output logic             busy,
   output logic             done,
   output logic             timeout_err,
   output logic             rejected,
   output logic [7:0]       sysref_cnt
);

   localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, ARM, ACTIVE, HOLDOFF} state_e;

   state_e state, next_state;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sr_prev;
   logic                   sr_edge;

   logic [DLY_W-1:0] dly_q, edge_cnt;
   logic [LEN_W-1:0] len_q, gap_q, len_cnt, gap_cnt, len_last;
   logic [TO_W-1:0]  to_cnt;
   logic             cap_en_q, play_en_q;

   logic accept, to_hit, abort_req;
   logic capture_d, play_d, busy_d, done_d, rejected_d;

   // Edge detect on the synchronizer output against its previous sample.
   assign sr_edge   = sync_q[SYNC_STAGES-1] & ~sr_prev;
   // Master dropping mid-run is handled exactly like an abort.
   assign abort_req = cmd_abort | ~master;
   // Last window cycle index; a zero length still yields a one-cycle window.
   assign len_last  = (len_q == '0) ? '0 : len_q - LEN_W'(1);

   // State register plus synchronizer and sticky status.
   always_ff @(posedge pl_adc_clk) begin
      // NOTE: every clocked assignment is non-blocking so that all flops sample
      // the pre-edge values regardless of statement order.
      if (pl_rst) begin
         state       <= IDLE;
         sync_q      <= '0;
         sr_prev     <= 1'b0;
         sysref_cnt  <= '0;
         timeout_err <= 1'b0;
      end else begin
         state   <= next_state;
         sync_q  <= {sync_q[SYNC_STAGES-2:0], pl_sysref};
         sr_prev <= sync_q[SYNC_STAGES-1];
         if (sr_edge)
            sysref_cnt <= sysref_cnt + 8'd1;
         if (accept)
            timeout_err <= 1'b0;
         else if (to_hit)
            timeout_err <= 1'b1;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latches).
      next_state = state;
      accept     = 1'b0;
      to_hit     = 1'b0;
      unique case (state)
         IDLE: begin
            if (cmd_start && !cmd_abort && master && (cmd_capture_en || cmd_play_en)) begin
               accept     = 1'b1;
               next_state = ARM;
            end
         end
         ARM: begin
            if (abort_req)
               next_state = IDLE;
            else if (sr_edge && edge_cnt == dly_q)
               next_state = ACTIVE;        // an edge beats a coincident timeout
            else if (!sr_edge && to_cnt == TO_LAST) begin
               to_hit     = 1'b1;
               next_state = IDLE;
            end
         end
         ACTIVE: begin
            if (abort_req)
               next_state = IDLE;
            else if (len_cnt == len_last)
               next_state = (gap_q == '0) ? IDLE : HOLDOFF;
         end
         HOLDOFF: begin
            if (abort_req || gap_cnt == gap_q - LEN_W'(1))
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Output logic: values the output flops take at the next edge.
   always_comb begin
      capture_d  = (next_state == ACTIVE) && cap_en_q;
      play_d     = (next_state == ACTIVE) && play_en_q;
      busy_d     = (next_state != IDLE);
      done_d     = (state == ACTIVE || state == HOLDOFF) && next_state == IDLE && !abort_req;
      rejected_d = cmd_start && !accept && ((state == IDLE) ? !cmd_abort : !abort_req);
   end

   // Registered outputs, latched configuration and run counters.
   always_ff @(posedge pl_adc_clk) begin
      if (pl_rst) begin
         capture_in <= 1'b0;
         play_in    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         rejected   <= 1'b0;
         dly_q      <= '0;
         len_q      <= '0;
         gap_q      <= '0;
         cap_en_q   <= 1'b0;
         play_en_q  <= 1'b0;
         edge_cnt   <= '0;
         to_cnt     <= '0;
         len_cnt    <= '0;
         gap_cnt    <= '0;
      end else begin
         capture_in <= capture_d;
         play_in    <= play_d;
         busy       <= busy_d;
         done       <= done_d;
         rejected   <= rejected_d;

         if (accept) begin
            dly_q     <= cfg_dly_edges;
            len_q     <= cfg_len;
            gap_q     <= cfg_gap;
            cap_en_q  <= cmd_capture_en;
            play_en_q <= cmd_play_en;
         end

         // Counters run only while their state persists and clear otherwise.
         if (state == ARM && next_state == ARM) begin
            if (sr_edge) begin
               edge_cnt <= edge_cnt + DLY_W'(1);
               to_cnt   <= '0;
            end else if (to_cnt != TO_MAX) begin
               to_cnt   <= to_cnt + TO_W'(1);
            end
         end else begin
            edge_cnt <= '0;
            to_cnt   <= '0;
         end

         len_cnt <= (state == ACTIVE  && next_state == ACTIVE)  ? len_cnt + LEN_W'(1) : '0;
         gap_cnt <= (state == HOLDOFF && next_state == HOLDOFF) ? gap_cnt + LEN_W'(1) : '0;
      end
   end

endmodule
